// File: rtl/eth_packet_tx.sv
// Ethernet frame transmitter: preamble, SFD, header, payload, zero pad, FCS and inter-frame gap.
// Optional macro ETH_TX_CRC32_EN selects a real IEEE 802.3 CRC-32 FCS; otherwise the FCS is FF FF FF FF.
module eth_packet_tx #(
  parameter int IFG_CYCLES  = 1,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [47:0] dst_addr_i,
  input  logic [47:0] src_addr_i,
  input  logic [15:0] type_length_i,
  input  logic [10:0] payload_len_i,
  input  logic [7:0]  payload_data_i,
  output logic        payload_req_o,
  output logic [7:0]  data_o,
  output logic        control_o,
  output logic        busy_o,
  output logic        tx_done_o,
  output logic [3:0]  tx_packet_counter_o
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PRE  = 4'd1;
  localparam logic [3:0] S_SFD  = 4'd2;
  localparam logic [3:0] S_DST  = 4'd3;
  localparam logic [3:0] S_SRC  = 4'd4;
  localparam logic [3:0] S_TYPE = 4'd5;
  localparam logic [3:0] S_PAY  = 4'd6;
  localparam logic [3:0] S_PAD  = 4'd7;
  localparam logic [3:0] S_FCS  = 4'd8;
  localparam logic [3:0] S_IFG  = 4'd9;

  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  logic [3:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [7:0]  data_q, data_d;
  logic        control_q, control_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  pkt_q, pkt_d;
  logic [10:0] pad_len_s;
  logic [10:0] last_idx_s;
  logic        accept_s;
  logic [7:0]  fcs_byte_s;

  function automatic logic [7:0] field_byte(input logic [47:0] v, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = v[47:40];
      3'd1:    b = v[39:32];
      3'd2:    b = v[31:24];
      3'd3:    b = v[23:16];
      3'd4:    b = v[15:8];
      3'd5:    b = v[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef ETH_TX_CRC32_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // crc_d already includes the byte leaving the wire, so FCS byte 0 is ready on time
  always_comb begin
    crc_d = crc_q;
    if (accept_s) begin
      crc_d = 32'hFFFFFFFF;
    end else if ((state_q >= S_DST) && (state_q <= S_PAD)) begin
      crc_d = crc32_byte(crc_q, data_q);
    end else begin
      crc_d = crc_q;
    end
    case (cnt_d[1:0])
      2'd0:    fcs_byte_s = ~crc_d[7:0];
      2'd1:    fcs_byte_s = ~crc_d[15:8];
      2'd2:    fcs_byte_s = ~crc_d[23:16];
      2'd3:    fcs_byte_s = ~crc_d[31:24];
      default: fcs_byte_s = 8'hFF;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign fcs_byte_s = 8'hFF;
`endif

  // state sequencing; state_q/cnt_q describe the byte currently on the output
  always_comb begin
    pad_len_s = (len_q < MIN_LEN) ? (MIN_LEN - len_q) : 11'd0;
    accept_s  = start_i && ((state_q == S_IDLE) ||
                            ((state_q == S_IFG) && (cnt_q == IFG_LAST)));
    case (state_q)
      S_PRE:   last_idx_s = 11'd6;
      S_SFD:   last_idx_s = 11'd0;
      S_DST:   last_idx_s = 11'd5;
      S_SRC:   last_idx_s = 11'd5;
      S_TYPE:  last_idx_s = 11'd1;
      S_PAY:   last_idx_s = len_q - 11'd1;
      S_PAD:   last_idx_s = pad_len_s - 11'd1;
      S_FCS:   last_idx_s = 11'd3;
      S_IFG:   last_idx_s = IFG_LAST;
      default: last_idx_s = 11'd0;
    endcase

    state_d = state_q;
    cnt_d   = 11'd0;
    len_d   = len_q;
    dst_d   = dst_q;
    src_d   = src_q;
    type_d  = type_q;
    if (accept_s) begin
      state_d = S_PRE;
      len_d   = (payload_len_i > MAX_LEN) ? MAX_LEN : payload_len_i;
      dst_d   = dst_addr_i;
      src_d   = src_addr_i;
      type_d  = type_length_i;
    end else if (state_q == S_IDLE) begin
      state_d = S_IDLE;
    end else if (cnt_q != last_idx_s) begin
      cnt_d = cnt_q + 11'd1;
    end else begin
      case (state_q)
        S_PRE:   state_d = S_SFD;
        S_SFD:   state_d = S_DST;
        S_DST:   state_d = S_SRC;
        S_SRC:   state_d = S_TYPE;
        S_TYPE:  state_d = (len_q != 11'd0) ? S_PAY :
                           ((pad_len_s != 11'd0) ? S_PAD : S_FCS);
        S_PAY:   state_d = (pad_len_s != 11'd0) ? S_PAD : S_FCS;
        S_PAD:   state_d = S_FCS;
        S_FCS:   state_d = S_IFG;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // next-cycle outputs decoded from the next state so every output is a flop
  always_comb begin
    control_d = 1'b1;
    case (state_d)
      S_PRE:   data_d = 8'h55;
      S_SFD:   data_d = 8'hD5;
      S_DST:   data_d = field_byte(dst_q, cnt_d[2:0]);
      S_SRC:   data_d = field_byte(src_q, cnt_d[2:0]);
      S_TYPE:  data_d = cnt_d[0] ? type_q[7:0] : type_q[15:8];
      S_PAY:   data_d = payload_data_i;
      S_PAD:   data_d = 8'h00;
      S_FCS:   data_d = fcs_byte_s;
      default: begin
        data_d    = 8'h00;
        control_d = 1'b0;
      end
    endcase
    req_d  = ((state_d == S_TYPE) && (cnt_d == 11'd1) && (len_q != 11'd0)) ||
             ((state_d == S_PAY) && (cnt_d != (len_q - 11'd1)));
    busy_d = (state_d != S_IDLE) && !((state_d == S_IFG) && (cnt_d == IFG_LAST));
    done_d = (state_d == S_FCS) && (cnt_d == 11'd3);
    pkt_d  = ((state_q == S_FCS) && (cnt_q == 11'd3)) ? (pkt_q + 4'd1) : pkt_q;
  end

  // state and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      len_q     <= 11'd0;
      dst_q     <= 48'd0;
      src_q     <= 48'd0;
      type_q    <= 16'd0;
      data_q    <= 8'h00;
      control_q <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pkt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      type_q    <= type_d;
      data_q    <= data_d;
      control_q <= control_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pkt_q     <= pkt_d;
    end
  end

  assign payload_req_o       = req_q;
  assign data_o              = data_q;
  assign control_o           = control_q;
  assign busy_o              = busy_q;
  assign tx_done_o           = done_q;
  assign tx_packet_counter_o = pkt_q;

endmodule

// File: tb/tb_eth_packet_tx.sv
// Self-checking bench for eth_packet_tx: frames are predicted from the field values and payload bytes.
module tb_eth_packet_tx;
  localparam int IFG     = 3;
  localparam int MINP    = 46;
  localparam int MAXP    = 1500;
  localparam int REQ_IDX = 21;

  logic        clk = 1'b0;
  logic        reset_i, start_i;
  logic [47:0] dst_i, src_i;
  logic [15:0] type_i;
  logic [10:0] len_i;
  logic [7:0]  pdata_i;
  logic        payload_req_o, control_o, busy_o, tx_done_o;
  logic [7:0]  data_o;
  logic [3:0]  tx_packet_counter_o;

  int n_cmp = 0;
  int n_bad = 0;
  int pkt_model = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];

  eth_packet_tx #(.IFG_CYCLES(IFG), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i),
    .dst_addr_i(dst_i), .src_addr_i(src_i), .type_length_i(type_i),
    .payload_len_i(len_i), .payload_data_i(pdata_i),
    .payload_req_o(payload_req_o), .data_o(data_o), .control_o(control_o),
    .busy_o(busy_o), .tx_done_o(tx_done_o), .tx_packet_counter_o(tx_packet_counter_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // expected wire bytes of one frame, built straight from the field values
  task automatic build_expected(input logic [47:0] dst, input logic [47:0] src,
                                input logic [15:0] typ, input int plen, input int fill);
    int L;
    logic [31:0] crc;
    exp_q.delete();
    pl_q.delete();
    L = (plen > MAXP) ? MAXP : plen;
    for (int i = 0; i < L; i++) pl_q.push_back((fill >= 0) ? 8'(fill) : 8'($urandom));
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(dst >> (8 * (5 - i))));
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(src >> (8 * (5 - i))));
    exp_q.push_back(typ[15:8]);
    exp_q.push_back(typ[7:0]);
    for (int i = 0; i < L; i++) exp_q.push_back(pl_q[i]);
    for (int i = L; i < MINP; i++) exp_q.push_back(8'h00);
    crc = 32'hFFFFFFFF;
`ifdef ETH_TX_CRC32_EN
    for (int i = 8; i < exp_q.size(); i++) begin
      crc = crc ^ {24'h0, exp_q[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
`endif
    crc = ~crc;
`ifndef ETH_TX_CRC32_EN
    crc = 32'hFFFFFFFF;
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(crc >> (8 * i)));
  endtask

  // called just after the accepting edge; returns at the negedge of the first IFG cycle
  task automatic capture_frame(input string tag, input bit drop_start);
    logic [7:0] got[$];
    int rq_cnt = 0, rq_bad = 0, done_cnt = 0, done_bad = 0, busy_bad = 0, byte_bad = 0;
    int guard = 0;
    @(negedge clk);
    if (drop_start) start_i = 1'b0;
    check({tag, " first_byte"}, {control_o, data_o}, {1'b1, 8'h55});
    while (control_o === 1'b1 && guard < 2000) begin
      got.push_back(data_o);
      if (busy_o !== 1'b1) busy_bad++;
      if (tx_done_o === 1'b1) begin
        done_cnt++;
        if (got.size() != exp_q.size()) done_bad++;
      end
      if (payload_req_o === 1'b1) begin
        if (got.size() - 1 != REQ_IDX + rq_cnt) rq_bad++;
        pdata_i = (rq_cnt < pl_q.size()) ? pl_q[rq_cnt] : 8'($urandom);
        rq_cnt++;
      end else begin
        pdata_i = 8'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) byte_bad++;
    pkt_model = (pkt_model + 1) % 16;
    check({tag, " frame_len"}, got.size(), exp_q.size());
    check({tag, " bytes_bad"}, byte_bad, 0);
    check({tag, " req_count"}, rq_cnt, pl_q.size());
    check({tag, " req_timing_bad"}, rq_bad, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_pos_bad"}, done_bad, 0);
    check({tag, " busy_bad"}, busy_bad, 0);
    check({tag, " counter"}, tx_packet_counter_o, pkt_model);
  endtask

  task automatic check_gap(input string tag, input bit expect_next);
    int gap_bad = 0;
    for (int i = 0; i < IFG; i++) begin
      if (i > 0) @(negedge clk);
      if (control_o !== 1'b0 || data_o !== 8'h00 || payload_req_o !== 1'b0 || tx_done_o !== 1'b0)
        gap_bad++;
      if (busy_o !== ((i < IFG - 1) ? 1'b1 : 1'b0)) gap_bad++;
    end
    check({tag, " ifg_bad"}, gap_bad, 0);
    if (!expect_next) begin
      @(negedge clk);
      check({tag, " idle_after"}, {control_o, busy_o}, 2'b00);
    end
  endtask

  task automatic send_frame(input string tag, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input logic [10:0] plen, input int fill);
    build_expected(dst, src, typ, int'(plen), fill);
    dst_i = dst; src_i = src; type_i = typ; len_i = plen; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    dst_i = {$urandom, $urandom};
    src_i = {$urandom, $urandom};
    type_i = 16'($urandom);
    len_i = 11'($urandom);
    capture_frame(tag, 1'b0);
    check_gap(tag, 1'b0);
  endtask

  task automatic reset_state_check(input string tag);
    check({tag, " data"}, data_o, 8'h00);
    check({tag, " control"}, control_o, 1'b0);
    check({tag, " req"}, payload_req_o, 1'b0);
    check({tag, " busy"}, busy_o, 1'b0);
    check({tag, " done"}, tx_done_o, 1'b0);
    check({tag, " counter"}, tx_packet_counter_o, 4'd0);
  endtask

  initial begin
    logic [47:0] d, s;
    logic [15:0] t;
    reset_i = 1'b1; start_i = 1'b0; dst_i = '0; src_i = '0; type_i = '0; len_i = '0; pdata_i = '0;
    repeat (3) @(negedge clk);
    reset_state_check("reset");
    reset_i = 1'b0;
    @(negedge clk);

    send_frame("basic46", 48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd46, 8'h55);
    send_frame("len10", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 11'd10, -1);
    send_frame("len0", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 11'd0, -1);
    send_frame("len1", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 11'd1, -1);

    // start held high: second frame follows after exactly IFG idle cycles
    d = {$urandom, $urandom}; s = {$urandom, $urandom}; t = 16'($urandom);
    build_expected(d, s, t, 20, -1);
    dst_i = d; src_i = s; type_i = t; len_i = 11'd20; start_i = 1'b1;
    @(posedge clk);
    #1;
    capture_frame("b2b_a", 1'b0);
    check_gap("b2b_a", 1'b1);
    capture_frame("b2b_b", 1'b1);
    check_gap("b2b_b", 1'b0);

    // abort during the source address
    s = {$urandom, $urandom};
    dst_i = {$urandom, $urandom}; src_i = s; type_i = 16'($urandom); len_i = 11'd50; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (18) @(negedge clk);
    check("abort src3", {control_o, data_o}, {1'b1, 8'(s >> 16)});
    reset_i = 1'b1;
    @(negedge clk);
    reset_state_check("abort");
    pkt_model = 0;
    start_i = 1'b1;
    @(negedge clk);
    check("rst_prio", {control_o, busy_o, data_o}, {1'b0, 1'b0, 8'h00});
    reset_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("rst_prio idle", {control_o, busy_o}, 2'b00);

    send_frame("post_rst", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
               11'($urandom_range(0, 60)), -1);
    send_frame("clamp2000", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 11'd2000, -1);
    for (int k = 0; k < 14; k++)
      send_frame("wrap", {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
                 11'($urandom_range(0, 80)), -1);
    check("wrap_to_zero", tx_packet_counter_o, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_packet_tx.md
ETH_PACKET_TX -- requirements
Module: eth_packet_tx

Interface
REQ-001 Parameter IFG_CYCLES, default 1, number of inter-frame gap cycles (control=0) after the FCS; legal range 1..15.
REQ-002 Parameter MIN_PAYLOAD, default 46, minimum payload length; shorter payloads are zero-padded.
REQ-003 Parameter MAX_PAYLOAD, default 1500, maximum payload length; larger requests are clamped.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to send one packet; sampled only when busy=0.
REQ-007 dst_addr  in  48  destination address; byte [47:40] sent first.
REQ-008 src_addr  in  48  source address; byte [47:40] sent first.
REQ-009 type_length  in  16  type/length field; byte [15:8] sent first.
REQ-010 payload_len  in  11  payload byte count, excluding pad and FCS.
REQ-011 payload_data  in  8  payload byte, sampled on the edge ending a payload_req=1 cycle.
REQ-012 payload_req  out  1  registered; high for exactly one cycle per payload byte to fetch.
REQ-013 data  out  8  registered transmit byte.
REQ-014 control  out  1  registered; 1 = data byte valid (frame), 0 = idle/IFG with data=8'h00.
REQ-015 busy  out  1  high from start acceptance through the penultimate IFG cycle.
REQ-016 tx_done  out  1  one-cycle pulse coincident with the last FCS byte.
REQ-017 tx_packet_counter  out  4  count of completed packets; wraps 15->0.

Function
REQ-018 States: IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG.
REQ-019 IDLE: control=0, data=8'h00; start=1 latches all field inputs and len=min(payload_len, MAX_PAYLOAD), enters PREAMBLE next cycle.
REQ-020 Latency: start sampled at edge T -> first 8'h55 with control=1 in cycle after T.
REQ-021 PREAMBLE 7 cycles of 8'h55; SFD 1 cycle of 8'hD5; DST 6; SRC 6; TYPE 2 cycles.
REQ-022 PAYLOAD lasts len cycles, each data byte equals payload_data sampled in the preceding payload_req cycle; payload_req is high during the last TYPE cycle and every PAYLOAD cycle except the last.
REQ-023 len=0 skips PAYLOAD, no payload_req asserted.
REQ-024 PAD lasts max(0, MIN_PAYLOAD-len) cycles of 8'h00.
REQ-025 FCS lasts 4 cycles; tx_done=1 and tx_packet_counter increments on the edge ending the 4th.
REQ-026 IFG lasts IFG_CYCLES cycles of control=0, data=8'h00; busy=0 in the final IFG cycle; start then accepted, giving exactly IFG_CYCLES gap cycles between frames; otherwise IDLE.
REQ-027 start while busy=1 is ignored; field inputs changing mid-frame have no effect.
REQ-028 control=1 never drops mid-frame; frame length = 8+14+max(len,MIN_PAYLOAD)+4 cycles.

Reset
REQ-029 reset=1 at any edge, including mid-frame, forces IDLE on the next cycle: data=8'h00, control=0, payload_req=0, busy=0, tx_done=0, tx_packet_counter=0; the aborted frame is not counted.
REQ-030 reset has priority over start in the same cycle.

Configuration
REQ-031 Macro ETH_TX_CRC32_EN defined: FCS = IEEE 802.3 CRC-32 (reflected poly 32'hEDB88320, init 32'hFFFFFFFF, final inversion) over DST through PAD, sent least-significant byte first.
REQ-032 Macro ETH_TX_CRC32_EN undefined: no CRC logic; FCS is four bytes of 8'hFF.

Verification
REQ-033 Reset, start with dst=01..06, src=FF..FA, type=16'h0800, len=46, payload=8'h55 -> 72 control=1 cycles: 7x55, D5, 01..06, FF..FA, 08, 00, 46x55, FCS; tx_done once; counter=1.
REQ-034 len=10 -> 10 payload_req pulses, 10 payload bytes, 36x 8'h00 pad, total frame still 72 cycles.
REQ-035 Two back-to-back starts with IFG_CYCLES=3, start held high -> exactly 3 control=0 cycles between frames; second start during frame ignored; counter=2.
REQ-036 reset asserted during SRC byte 3 -> next cycle control=0, data=00, counter=0; new start yields complete frame.
REQ-037 ETH_TX_CRC32_EN defined, frame REQ-033 -> FCS matches software CRC-32 reference; undefined -> FCS = FF FF FF FF.
REQ-038 payload_len=2000 -> 1500 payload bytes sent, no pad; 16 packets -> counter wraps to 0.
